// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: frame sequencer for the ADC -> FFT -> SPI-out chain.
// Paces ADC conversions, fills the FFT input buffer, launches the FFT, hands
// the result to the SPI output block, then idles for a gap and repeats
// (enable) or stops (single_shot).
// Optional build macro FFT_SCHED_WATCHDOG_EN adds a cycle watchdog on the
// FFT_RUN / SPI_ARM / SPI_WAIT states; without it those states wait forever.
module fft_frame_scheduler #(
  parameter int unsigned N_POINTS   = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned FRAME_GAP  = 256,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              single_shot,
  output logic              adc_sample,
  input  logic              adc_done,
  output logic [ADDR_W-1:0] fft_addr,
  output logic              fft_insert,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              spi_start,
  input  logic              spi_busy,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              err_timeout
);

  localparam int unsigned TickW = $clog2(SAMPLE_DIV);
  localparam int unsigned GapW  = $clog2(FRAME_GAP + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_POINTS - 1);
  localparam logic [TickW-1:0]  TickMax  = TickW'(SAMPLE_DIV - 1);
  localparam logic [GapW-1:0]   GapMax   = GapW'(FRAME_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StAcqWait, StAcqAdc, StInsert, StFftRun, StSpiArm, StSpiWait, StGap
  } state_e;

  state_e            state_q, state_d;
  state_e            prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic              pend_q, pend_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [7:0]        frame_q, frame_d;
  logic              err_q, err_d;

  logic tick;
  logic last;
  logic acq;
  logic overrun;
  logic wd_expire;

  assign tick = (tick_q == '0);
  assign last = (addr_q == LastAddr);
  assign acq  = (state_q == StAcqWait) || (state_q == StAcqAdc) || (state_q == StInsert);

`ifdef FFT_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_state;

  assign wd_state  = (state_q == StFftRun) || (state_q == StSpiArm) || (state_q == StSpiWait);
  assign wd_expire = wd_state && (wd_q == WdMax);

  // Watchdog count restarts whenever the state changes.
  always_comb begin
    wd_d = '0;
    if (wd_state && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // State register; prev_q marks the first cycle of a state for launch pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prev_q  <= StIdle;
    end else begin
      state_q <= state_d;
      prev_q  <= state_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    overrun = 1'b0;
    unique case (state_q)
      StIdle:    if (enable || single_shot) state_d = StAcqWait;
      StAcqWait: if (tick || pend_q) state_d = StAcqAdc;
      StAcqAdc: begin
        // A new tick before the sample returned means the ADC fell behind.
        if (tick) begin
          overrun = 1'b1;
          state_d = StIdle;
        end else if (adc_done) begin
          state_d = StInsert;
        end
      end
      StInsert:  state_d = last ? StFftRun : StAcqWait;
      StFftRun:  if (fft_done) state_d = StSpiArm;
      StSpiArm:  if (spi_busy) state_d = StSpiWait;
      StSpiWait: if (!spi_busy) state_d = StGap;
      StGap:     if (gap_q == GapMax) state_d = enable ? StAcqWait : StIdle;
      default:   state_d = StIdle;
    endcase
    if (wd_expire) begin
      state_d = StIdle;
    end
  end

  // Datapath next values: address, sample tick, gap counter, frame count, error.
  always_comb begin
    addr_d  = addr_q;
    tick_d  = '0;
    pend_d  = pend_q;
    gap_d   = '0;
    frame_d = frame_q;
    err_d   = err_q | overrun | wd_expire;

    if (acq) begin
      tick_d = (tick_q == TickMax) ? '0 : tick_q + 1'b1;
    end

    if ((state_q == StInsert) && !last) begin
      addr_d = addr_q + 1'b1;
    end
    if (((state_q == StIdle) || (state_q == StGap)) && (state_d == StAcqWait)) begin
      addr_d = '0;
    end

    // A tick landing on the insert cycle is held so the sample is not lost.
    if ((state_q == StInsert) && tick && !last) begin
      pend_d = 1'b1;
    end else if (adc_sample) begin
      pend_d = 1'b0;
    end
    if (state_d == StIdle) begin
      pend_d = 1'b0;
    end

    if (state_q == StGap) begin
      gap_d = gap_q + 1'b1;
    end

    if ((state_q == StSpiWait) && (state_d == StGap)) begin
      frame_d = frame_q + 8'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      tick_q  <= '0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    adc_sample  = (state_q == StAcqWait) && (tick || pend_q);
    fft_insert  = (state_q == StInsert);
    fft_start   = (state_q == StFftRun) && (prev_q == StInsert);
    spi_start   = (state_q == StSpiArm) && (prev_q == StFftRun);
    busy        = (state_q != StIdle);
    fft_addr    = addr_q;
    frame_cnt   = frame_q;
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with behavioural ADC, FFT and SPI
// responders. Covers single shot, continuous, overrun, reset abort, missing
// fft_done (watchdog build or not), ignored single_shot and frame_cnt wrap.
module tb_fft_frame_scheduler;

  localparam int NP   = 16;
  localparam int SDIV = 8;
  localparam int GAP  = 4;
  localparam int TOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       single_shot = 1'b0;
  logic       adc_done = 1'b0;
  logic       fft_done = 1'b0;
  logic       spi_busy = 1'b0;
  logic       adc_sample, fft_insert, fft_start, spi_start, busy, err_timeout;
  logic [3:0] fft_addr;
  logic [7:0] frame_cnt;

  fft_frame_scheduler #(
    .N_POINTS  (NP),
    .ADDR_W    (4),
    .SAMPLE_DIV(SDIV),
    .FRAME_GAP (GAP),
    .TIMEOUT   (TOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .single_shot(single_shot),
    .adc_sample (adc_sample),
    .adc_done   (adc_done),
    .fft_addr   (fft_addr),
    .fft_insert (fft_insert),
    .fft_start  (fft_start),
    .fft_done   (fft_done),
    .spi_start  (spi_start),
    .spi_busy   (spi_busy),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Responder controls, written only by the stimulus block.
  int suppress_idx = 0;
  bit fft_never = 1'b0;

  // Monitor state, written only by the monitor.
  int cyc = 0;
  int n_sample = 0, n_insert = 0, n_fstart = 0, n_sstart = 0;
  int spacing_err = 0, lat_err = 0, addr_err = 0, excl_err = 0;
  int last_sample_cyc = -1, last_done_cyc = -100, last_insert_cyc = -100;
  int last_fdone_cyc = -100;
  int exp_addr = 0, frame_samp = 0;
  int adc_cd = 0, fft_cd = 0, spi_cd = 0;
  int frame_inc_cyc = 0, busy_fall_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] fc_prev = 8'd0;

  // ADC: done 3 cycles after sample. FFT: done 20 cycles after start.
  // SPI: busy for 30 cycles starting 1 cycle after spi_start.
  always @(negedge clk) begin
    cyc = cyc + 1;
    adc_done = (adc_cd == 1);
    if (adc_cd > 0) adc_cd = adc_cd - 1;
    if (adc_done) last_done_cyc = cyc;
    fft_done = (fft_cd == 1);
    if (fft_cd > 0) fft_cd = fft_cd - 1;
    if (fft_done) last_fdone_cyc = cyc;
    if (spi_cd > 0) begin
      spi_busy = 1'b1;
      spi_cd = spi_cd - 1;
    end else begin
      spi_busy = 1'b0;
    end

    if ((32'(adc_sample) + 32'(fft_insert) + 32'(fft_start) + 32'(spi_start)) > 1)
      excl_err = excl_err + 1;
    if (adc_sample) begin
      n_sample = n_sample + 1;
      frame_samp = frame_samp + 1;
      if (last_sample_cyc >= 0 && (cyc - last_sample_cyc) != SDIV) spacing_err = spacing_err + 1;
      last_sample_cyc = cyc;
      if (frame_samp != suppress_idx) adc_cd = 3;
    end
    if (fft_insert) begin
      n_insert = n_insert + 1;
      if (cyc != last_done_cyc + 1) lat_err = lat_err + 1;
      if (int'(fft_addr) != exp_addr) addr_err = addr_err + 1;
      exp_addr = (exp_addr + 1) % NP;
      last_insert_cyc = cyc;
    end
    if (fft_start) begin
      n_fstart = n_fstart + 1;
      if (cyc != last_insert_cyc + 1 || int'(fft_addr) != NP - 1) lat_err = lat_err + 1;
      last_sample_cyc = -1;
      frame_samp = 0;
      if (!fft_never) fft_cd = 20;
    end
    if (spi_start) begin
      n_sstart = n_sstart + 1;
      if (cyc != last_fdone_cyc + 1) lat_err = lat_err + 1;
      spi_cd = 30;
    end
    if (busy !== 1'b1) begin
      exp_addr = 0;
      last_sample_cyc = -1;
      frame_samp = 0;
    end
    if (frame_cnt != fc_prev) frame_inc_cyc = cyc;
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    fc_prev = frame_cnt;
    busy_prev = busy;
  end

  int n_checks = 0;
  int n_errors = 0;
  int s_sample, s_insert, s_fstart, s_sstart;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_sample = n_sample;
    s_insert = n_insert;
    s_fstart = n_fstart;
    s_sstart = n_sstart;
  endtask

  task automatic pulse_ss();
    single_shot = 1'b1;
    step();
    single_shot = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < lim) begin
      step();
      k++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_samples(input int target, input int lim, input string tag);
    int k = 0;
    while (n_sample - s_sample < target && k < lim) begin
      step();
      k++;
    end
    chk(tag, n_sample - s_sample, target);
  endtask

  task automatic wait_fstart(input int lim, input string tag);
    int k = 0;
    while (n_fstart - s_fstart < 1 && k < lim) begin
      step();
      k++;
    end
    chk(tag, n_fstart - s_fstart, 1);
  endtask

  initial begin
    int k;
    // Reset state
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_adc_sample", adc_sample, 0);
    chk("rst_fft_insert", fft_insert, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_fft_addr", fft_addr, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    step();

    // Single frame
    snap();
    pulse_ss();
    chk("ss_first_sample", adc_sample, 1);
    chk("ss_busy", busy, 1);
    wait_idle(400, "ss_done");
    chk("ss_samples", n_sample - s_sample, 16);
    chk("ss_inserts", n_insert - s_insert, 16);
    chk("ss_fft_start", n_fstart - s_fstart, 1);
    chk("ss_spi_start", n_sstart - s_sstart, 1);
    chk("ss_frame_cnt", frame_cnt, 1);
    chk("ss_err", err_timeout, 0);
    chk("ss_gap_len", busy_fall_cyc - frame_inc_cyc, GAP);
    chk("ss_addr_err", addr_err, 0);
    chk("ss_spacing_err", spacing_err, 0);
    chk("ss_lat_err", lat_err, 0);

    // Continuous: drop enable during the third frame's acquisition
    snap();
    enable = 1'b1;
    k = 0;
    while (n_insert - s_insert < 2 * NP + 3 && k < 1000) begin
      step();
      k++;
    end
    enable = 1'b0;
    chk("cont_busy_mid", busy, 1);
    wait_idle(600, "cont_done");
    chk("cont_frame_cnt", frame_cnt, 4);
    chk("cont_samples", n_sample - s_sample, 48);
    chk("cont_inserts", n_insert - s_insert, 48);
    chk("cont_fft_start", n_fstart - s_fstart, 3);
    chk("cont_spi_start", n_sstart - s_sstart, 3);
    chk("cont_addr_err", addr_err, 0);
    chk("cont_spacing_err", spacing_err, 0);
    chk("cont_lat_err", lat_err, 0);

    // ADC overrun: fifth sample never completes
    snap();
    suppress_idx = 5;
    pulse_ss();
    wait_samples(5, 200, "ovr_reach5");
    step(SDIV);
    chk("ovr_err_before", err_timeout, 0);
    chk("ovr_busy_before", busy, 1);
    chk("ovr_no_sample6", adc_sample, 0);
    step();
    chk("ovr_err", err_timeout, 1);
    chk("ovr_idle", busy, 0);
    step(20);
    chk("ovr_samples", n_sample - s_sample, 5);
    chk("ovr_inserts", n_insert - s_insert, 4);
    chk("ovr_no_fft_start", n_fstart - s_fstart, 0);
    chk("ovr_frame_cnt", frame_cnt, 4);
    suppress_idx = 0;

    // Reset clears sticky error, then reset mid-frame at sample 7
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_err", err_timeout, 0);
    chk("rst2_frame_cnt", frame_cnt, 0);
    snap();
    pulse_ss();
    wait_samples(7, 200, "mid_reach7");
    chk("mid_addr_before", fft_addr, 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_adc_sample", adc_sample, 0);
    chk("mid_fft_insert", fft_insert, 0);
    chk("mid_fft_start", fft_start, 0);
    chk("mid_spi_start", spi_start, 0);
    chk("mid_fft_addr", fft_addr, 0);
    chk("mid_busy", busy, 0);
    step(8);
    chk("mid_stray_done", n_insert - s_insert, 6);
    chk("mid_samples", n_sample - s_sample, 7);

    // fft_done never arrives
    snap();
    fft_never = 1'b1;
    pulse_ss();
    wait_fstart(400, "wd_reach_fft");
`ifdef FFT_SCHED_WATCHDOG_EN
    step(TOUT - 1);
    chk("wd_err_before", err_timeout, 0);
    chk("wd_busy_before", busy, 1);
    step();
    chk("wd_err", err_timeout, 1);
    chk("wd_idle", busy, 0);
`else
    step(200);
    chk("nowd_busy", busy, 1);
    chk("nowd_err", err_timeout, 0);
`endif
    chk("wd_no_spi", n_sstart - s_sstart, 0);
    fft_never = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("wd_recover", busy, 0);

    // single_shot during FFT_RUN is ignored
    snap();
    pulse_ss();
    wait_fstart(400, "ign_reach_fft");
    step(2);
    pulse_ss();
    wait_idle(300, "ign_done");
    step(10);
    chk("ign_still_idle", busy, 0);
    chk("ign_frame_cnt", frame_cnt, 1);
    chk("ign_samples", n_sample - s_sample, 16);
    chk("ign_spi_start", n_sstart - s_sstart, 1);

    // 255 more frames wrap frame_cnt from 1 to 0
    snap();
    enable = 1'b1;
    k = 0;
    while (n_sstart - s_sstart < 255 && k < 60000) begin
      step();
      k++;
    end
    enable = 1'b0;
    wait_idle(400, "wrap_done");
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("wrap_spi_start", n_sstart - s_sstart, 255);
    chk("wrap_fft_start", n_fstart - s_fstart, 255);
    chk("wrap_addr_err", addr_err, 0);
    chk("wrap_lat_err", lat_err, 0);
    chk("wrap_spacing_err", spacing_err, 0);
    chk("excl_err", excl_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Frame-level sequencer for the acquisition → FFT → SPI-out chain; replaces the one-shot power-on start pulse.
- Paces ADC sample requests and writes each returned sample into the FFT input buffer at the next address.
- Launches the FFT, hands the result to the SPI output block, waits an inter-frame gap, then repeats (continuous) or stops (single shot).
- Sits between ADC_SPI, fft and fft_spi_out.

Parameters:
- N_POINTS, 16, samples per frame (power of 2, ≥2).
- ADDR_W, 4, FFT buffer address width, equal to log2(N_POINTS).
- SAMPLE_DIV, 1000, clk cycles between adc_sample pulses (≥4).
- FRAME_GAP, 256, idle cycles after SPI completes before the next frame (≥1).
- TIMEOUT, 65535, max wait cycles for fft_done, spi_busy rise or spi_busy fall (watchdog only).

Ports:
- clk  in  1  system clock (16 MHz)
- rst_n  in  1  synchronous active-low reset
- enable  in  1  level; continuous framing while high
- single_shot  in  1  one-cycle pulse; runs exactly one frame when idle
- adc_sample  out  1  one-cycle conversion request to ADC_SPI
- adc_done  in  1  one-cycle pulse: ADC data valid
- fft_addr  out  ADDR_W  buffer write address
- fft_insert  out  1  one-cycle write strobe
- fft_start  out  1  one-cycle FFT launch pulse
- fft_done  in  1  one-cycle FFT complete pulse
- spi_start  out  1  one-cycle pulse to fft_spi_out
- spi_busy  in  1  high while SPI transfer is active
- busy  out  1  high in every state except IDLE
- frame_cnt  out  8  completed frames, wraps 255→0
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge): state IDLE; all pulse outputs 0; fft_addr=0; frame_cnt=0; err_timeout=0; all counters cleared. Reset mid-frame aborts with no further pulses; a later sample or done pulse is ignored in IDLE.
- States: IDLE, ACQ_WAIT, ACQ_ADC, INSERT, FFT_RUN, SPI_ARM, SPI_WAIT, GAP.
- IDLE → ACQ_WAIT when enable=1 or single_shot=1; fft_addr=0, tick counter loaded.
- The first adc_sample fires the cycle after leaving IDLE. Subsequent adc_sample pulses fire exactly SAMPLE_DIV cycles apart, from a free-running tick during acquisition.
- ACQ_WAIT: issue adc_sample on tick, then go to ACQ_ADC.
- ACQ_ADC: on adc_done go to INSERT.
  - If the next tick arrives before adc_done, it is an overrun: set err_timeout, abort to IDLE, frame_cnt unchanged.
- INSERT: fft_insert=1 for one cycle with fft_addr=index.
  - index<N_POINTS-1: increment fft_addr and return to ACQ_WAIT.
  - index=N_POINTS-1: fft_addr stays at N_POINTS-1, fft_start pulses the next cycle, state becomes FFT_RUN.
- FFT_RUN: on fft_done, spi_start pulses the next cycle and the state becomes SPI_ARM.
- SPI_ARM: wait for spi_busy=1, then go to SPI_WAIT.
- SPI_WAIT: wait for spi_busy=0; then frame_cnt+1, go to GAP.
- GAP: count FRAME_GAP cycles, then:
  - enable=1: go to ACQ_WAIT (fft_addr=0).
  - otherwise: go to IDLE.
- Control inputs:
  - enable deasserted mid-frame: the current frame completes; no partial frames.
  - single_shot while busy: ignored.
  - single_shot and enable both high: continuous operation.
- Output exclusivity: at most one of adc_sample, fft_insert, fft_start, spi_start is high in any cycle.
- Latencies:
  - adc_done → fft_insert: 1 cycle.
  - Last insert → fft_start: 1 cycle.
  - fft_done → spi_start: 1 cycle.
- Unexpected adc_done or fft_done outside its wait state: ignored.
- err_timeout clears only on reset.

Optional Feature:
- Macro: FFT_SCHED_WATCHDOG_EN.
- Defined:
  - FFT_RUN, SPI_ARM and SPI_WAIT each count cycles.
  - Reaching TIMEOUT sets err_timeout and forces IDLE; frame_cnt is unchanged.
  - The counter restarts on each state entry.
- Undefined:
  - Those states wait indefinitely and no timeout counter is built.
  - err_timeout is set only by ADC overrun.

Test Plan:
- Bench parameters: N_POINTS=16, SAMPLE_DIV=8, FRAME_GAP=4, TIMEOUT=64.
- Single frame: pulse single_shot; model ADC done 3 cycles after each sample, fft_done 20 cycles after start, spi_busy high for 30 cycles starting 1 cycle after spi_start → 16 adc_sample pulses spaced 8; fft_insert addresses 0..15 in order; one fft_start; one spi_start; frame_cnt=1; busy=0 after the 4-cycle gap.
- Continuous: enable=1 for 3 frames, then deassert during the 3rd frame's acquisition → frame_cnt=3, then IDLE; the 3rd frame completes fully.
- ADC overrun: suppress adc_done for sample 5 → err_timeout=1 at the 6th tick; IDLE; frame_cnt unchanged; fft_start never asserted.
- Watchdog (macro defined): never assert fft_done → err_timeout=1 exactly 64 cycles after FFT_RUN entry; state IDLE. With the macro undefined → busy stays 1 and err_timeout stays 0.
- Reset mid-frame: rst_n=0 for one cycle at sample 7 → next cycle all outputs 0 and fft_addr=0; a following stray adc_done produces no fft_insert.
- Wrap and ignore: run 256 frames → frame_cnt wraps to 0. A single_shot pulse during FFT_RUN → no extra frame is started.
